// File: rtl/pe_array_loader.sv
// pe_array_loader: sequences one host word stream onto the PE array instruction chain, then its data-load chain
module pe_array_loader #(
    parameter int NUM_PE     = 8,
    parameter int DATA_WIDTH = 16,
    parameter int INST_WIDTH = 32,
    parameter int INST_DEPTH = 8,
    parameter int DATA_DEPTH = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [$clog2(INST_DEPTH+1)-1:0]   n_inst,
    input  logic [$clog2(DATA_DEPTH+1)-1:0]   n_data,
    input  logic                              abort,
    input  logic                              s_valid,
    output logic                              s_ready,
    input  logic [INST_WIDTH-1:0]             s_data,
    output logic                              inst_v,
    output logic [INST_WIDTH-1:0]             inst_in,
    output logic                              din_v,
    output logic [2*DATA_WIDTH-1:0]           din_ld,
    output logic                              busy,
    output logic                              done,
    output logic                              aborted
);
    localparam int NIW = $clog2(INST_DEPTH+1);
    localparam int NDW = $clog2(DATA_DEPTH+1);
    localparam int CW  = $clog2(NUM_PE*(INST_DEPTH > DATA_DEPTH ? INST_DEPTH : DATA_DEPTH)+1);
    typedef enum logic [1:0] {IDLE, LOAD_INST, LOAD_DATA, DONE} state_t;
    state_t          state;
    logic [NIW-1:0]  ni, ni_c;
    logic [NDW-1:0]  nd, nd_c;
    logic [CW-1:0]   cnt, cnt_inc, inst_tgt, data_tgt;
    assign ni_c     = (n_inst > NIW'(INST_DEPTH)) ? NIW'(INST_DEPTH) : n_inst;
    assign nd_c     = (n_data > NDW'(DATA_DEPTH)) ? NDW'(DATA_DEPTH) : n_data;
    assign inst_tgt = CW'(NUM_PE) * CW'(ni);
    assign data_tgt = CW'(NUM_PE) * CW'(nd);
    assign cnt_inc  = cnt + CW'(1);
    assign s_ready  = (state == LOAD_INST) || (state == LOAD_DATA);
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    // abort wins over a same-cycle accept: the offered word is dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ni      <= '0;
            nd      <= '0;
            cnt     <= '0;
            inst_v  <= 1'b0;
            inst_in <= '0;
            din_v   <= 1'b0;
            din_ld  <= '0;
            aborted <= 1'b0;
        end else begin
            inst_v  <= 1'b0;
            din_v   <= 1'b0;
            aborted <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    ni    <= ni_c;
                    nd    <= nd_c;
                    cnt   <= '0;
                    state <= (ni_c != '0) ? LOAD_INST : (nd_c != '0) ? LOAD_DATA : DONE;
                end
                LOAD_INST: if (abort) begin
                    state   <= IDLE;
                    aborted <= 1'b1;
                end else if (s_valid) begin
                    inst_v  <= 1'b1;
                    inst_in <= s_data;
                    cnt     <= (cnt_inc == inst_tgt) ? '0 : cnt_inc;
                    if (cnt_inc == inst_tgt)
                        state <= (nd != '0) ? LOAD_DATA : DONE;
                end
                LOAD_DATA: if (abort) begin
                    state   <= IDLE;
                    aborted <= 1'b1;
                end else if (s_valid) begin
                    din_v  <= 1'b1;
                    din_ld <= s_data[2*DATA_WIDTH-1:0];
                    cnt    <= (cnt_inc == data_tgt) ? '0 : cnt_inc;
                    if (cnt_inc == data_tgt)
                        state <= DONE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_array_loader.sv
// tb_pe_array_loader: randomized load sequences checked against a word-plan model through a scoreboard
module tb_pe_array_loader;
    localparam int NP = 8, DW = 16, IW = 32, ID = 8, DD = 16;
    logic          clk = 0, rst = 0, start = 0, abort = 0, s_valid = 0;
    logic [3:0]    n_inst = 0;
    logic [4:0]    n_data = 0;
    logic [IW-1:0] s_data = 0;
    logic          s_ready, inst_v, din_v, busy, done, aborted;
    logic [IW-1:0] inst_in;
    logic [2*DW-1:0] din_ld;

    pe_array_loader #(.NUM_PE(NP), .DATA_WIDTH(DW), .INST_WIDTH(IW), .INST_DEPTH(ID), .DATA_DEPTH(DD)) dut (
        .clk(clk), .rst(rst), .start(start), .n_inst(n_inst), .n_data(n_data), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .inst_v(inst_v), .inst_in(inst_in),
        .din_v(din_v), .din_ld(din_ld), .busy(busy), .done(done), .aborted(aborted)
    );

    always #5 clk = ~clk;

    typedef struct {bit is_data; logic [IW-1:0] w;} ent_t;
    ent_t sb[$];
    ent_t m_e;
    int   total = 0, bad = 0;
    int   n_iv = 0, n_dv = 0, n_done = 0, n_ab = 0;
    bit   m_active = 0, m_in_done = 0, m_fin = 0;
    int   m_k = 0, m_plan = 0, m_ni = 0;
    bit   e_iv = 0, e_dv = 0, e_done = 0, e_ab = 0, e_busy = 0, e_ready = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a load is a plan of NUM_PE*min(n,depth) instruction words followed by data words
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_active = 0; m_in_done = 0; sb.delete();
            e_iv = 0; e_dv = 0; e_done = 0; e_ab = 0; e_busy = 0; e_ready = 0;
        end else begin
            e_iv = 0; e_dv = 0; e_ab = 0; m_fin = 0;
            if (m_active) begin
                if (abort) begin
                    m_active = 0; e_ab = 1;
                end else if (s_valid) begin
                    sb.push_back('{m_k >= m_ni, (m_k >= m_ni) ? IW'(s_data[2*DW-1:0]) : s_data});
                    e_iv = m_k < m_ni;
                    e_dv = !e_iv;
                    m_k++;
                    if (m_k == m_plan) begin m_active = 0; m_fin = 1; end
                end
            end else if (!m_in_done && start) begin
                m_ni   = NP * ((n_inst > ID) ? ID : int'(n_inst));
                m_plan = m_ni + NP * ((n_data > DD) ? DD : int'(n_data));
                m_k    = 0;
                if (m_plan == 0) m_fin = 1; else m_active = 1;
            end
            m_in_done = m_fin;
            e_done    = m_fin;
            e_busy    = m_active || m_fin;
            e_ready   = m_active;
        end
    end

    always @(negedge clk) begin
        chk("inst_v", inst_v, e_iv);
        chk("din_v", din_v, e_dv);
        chk("done", done, e_done);
        chk("aborted", aborted, e_ab);
        chk("busy", busy, e_busy);
        chk("s_ready", s_ready, e_ready);
        if (inst_v || din_v) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                m_e = sb.pop_front();
                chk("kind", din_v, m_e.is_data);
                chk("word", inst_v ? inst_in : IW'(din_ld), m_e.w);
            end
        end
        n_iv   += int'(inst_v);
        n_dv   += int'(din_v);
        n_done += int'(done);
        n_ab   += int'(aborted);
    end

    task automatic run(input int ni, input int nd, input int pct, input int ab, input bit poke);
        int  cyc = 0;
        bit  ab_sent = 0;
        n_iv = 0; n_dv = 0; n_done = 0; n_ab = 0;
        @(posedge clk); #1;
        start = 1; n_inst = 4'(ni); n_data = 5'(nd);
        @(posedge clk); #1;
        start = 0;
        while ((m_active || m_in_done) && cyc < 3000) begin
            s_valid = $urandom_range(99) < pct;
            s_data  = $urandom;
            abort   = 0;
            if (ab >= 0 && !ab_sent && n_dv >= ab) begin abort = 1; s_valid = 1; ab_sent = 1; end
            start = poke && m_active && m_k >= m_ni && $urandom_range(3) == 0;
            if (start) begin n_inst = 4'($urandom); n_data = 5'($urandom); end
            @(posedge clk); #1;
            cyc++;
        end
        chk("timeout", 64'(cyc >= 3000), 0);
        s_valid = 0; abort = 0; start = 0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic chk_counts(input string tag, input int iv, input int dv, input int dn);
        chk({tag, "_inst_v_count"}, n_iv, iv);
        chk({tag, "_din_v_count"}, n_dv, dv);
        chk({tag, "_done_count"}, n_done, dn);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_inst_in", inst_in, 0);
        run(2, 3, 100, -1, 0);
        chk_counts("t1", 16, 24, 1);
        run(2, 3, 50, -1, 0);
        chk_counts("t2", 16, 24, 1);
        run(0, 1, 60, -1, 0);
        chk_counts("t3a", 0, 8, 1);
        run(0, 0, 100, -1, 0);
        chk_counts("t3b", 0, 0, 1);
        run(15, 1, 70, -1, 1);
        chk_counts("t4", 64, 8, 1);
        run(2, 3, 100, 5, 0);
        chk("t5_done_count", n_done, 0);
        chk("t5_aborted_count", n_ab, 1);
        chk("t5_partial", 64'(n_dv < 24 && n_iv == 16), 1);
        run(3, 2, 80, -1, 0);
        chk_counts("t5_fresh", 24, 16, 1);
        @(posedge clk); #1;
        start = 1; n_inst = 2; n_data = 3;
        @(posedge clk); #1;
        start = 0; s_valid = 1;
        repeat (4) @(posedge clk);
        #2 rst = 0;
        #1;
        chk("t6_inst_v", inst_v, 0);
        chk("t6_din_v", din_v, 0);
        chk("t6_s_ready", s_ready, 0);
        chk("t6_busy", busy, 0);
        s_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1;
        run(2, 3, 100, -1, 0);
        chk_counts("t6_rerun", 16, 24, 1);
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
